// File: rtl/cgram_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cgram_port_ctrl_if
// Brief    : CPU register strobes and CGRAM port-A bus for cgram_port_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface cgram_port_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 15
);
    logic              addr_wr;
    logic              data_wr;
    logic              data_rd;
    logic [7:0]        cpu_din;
    logic              open_bus7;
    logic [7:0]        cpu_dout;
    logic              rd_valid;
    logic              ready;
    logic              drop_err;
    logic [ADDR_W-1:0] ram_ada;
    logic [DATA_W-1:0] ram_dina;
    logic              ram_cea;
    logic              ram_wrea;
    logic [DATA_W-1:0] ram_douta;

    modport master (
        output addr_wr, data_wr, data_rd, cpu_din, open_bus7, ram_douta,
        input  cpu_dout, rd_valid, ready, drop_err,
               ram_ada, ram_dina, ram_cea, ram_wrea
    );

    modport slave (
        input  addr_wr, data_wr, data_rd, cpu_din, open_bus7, ram_douta,
        output cpu_dout, rd_valid, ready, drop_err,
               ram_ada, ram_dina, ram_cea, ram_wrea
    );
endinterface
`default_nettype wire

// File: rtl/cgram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cgram_port_ctrl
// Brief    : CPU-side byte sequencer for port A of the 256x15 palette RAM.
//            Optional macro CGRAM_CLEAR_EN zero-fills the RAM after reset.
// Revision : 1.0 - initial release
// ============================================================================
module cgram_port_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 15
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    cgram_port_ctrl_if.slave   bus
);
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RD_ADDR = 2'd1;
    localparam logic [1:0] c_ST_RD_DATA = 2'd2;
`ifdef CGRAM_CLEAR_EN
    localparam logic [1:0] c_ST_CLEAR   = 2'd3;
    localparam logic [1:0] c_ST_RESET   = c_ST_CLEAR;
`else
    localparam logic [1:0] c_ST_RESET   = c_ST_IDLE;
`endif

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] cg_addr_q,  cg_addr_d;
    logic              flip_q,     flip_d;
    logic [7:0]        lo_latch_q, lo_latch_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              drop_err_q, drop_err_d;
    logic [ADDR_W-1:0] ram_ada_q,  ram_ada_d;
    logic [DATA_W-1:0] ram_dina_q, ram_dina_d;
    logic              ram_cea_q,  ram_cea_d;
    logic              ram_wrea_q, ram_wrea_d;
`ifdef CGRAM_CLEAR_EN
    // Extra MSB marks that all entries have been issued.
    logic [ADDR_W:0]   clr_cnt_q,  clr_cnt_d;
`endif

    logic w_any_strobe;
    assign w_any_strobe = bus.addr_wr | bus.data_wr | bus.data_rd;

    always_comb begin
        state_d    = state_q;
        cg_addr_d  = cg_addr_q;
        flip_d     = flip_q;
        lo_latch_d = lo_latch_q;
        cpu_dout_d = cpu_dout_q;
        rd_valid_d = 1'b0;
        drop_err_d = drop_err_q;
        ram_ada_d  = ram_ada_q;
        ram_dina_d = ram_dina_q;
        ram_cea_d  = 1'b0;
        ram_wrea_d = 1'b0;
`ifdef CGRAM_CLEAR_EN
        clr_cnt_d  = clr_cnt_q;
`endif

        if (state_q != c_ST_IDLE && w_any_strobe) begin
            drop_err_d = 1'b1;
        end

        case (state_q)
            c_ST_IDLE: begin
                if (bus.addr_wr) begin
                    cg_addr_d = bus.cpu_din[ADDR_W-1:0];
                    flip_d    = 1'b0;
                end else if (bus.data_wr) begin
                    if (!flip_q) begin
                        lo_latch_d = bus.cpu_din;
                        flip_d     = 1'b1;
                    end else begin
                        ram_ada_d  = cg_addr_q;
                        ram_dina_d = {bus.cpu_din[DATA_W-9:0], lo_latch_q};
                        ram_cea_d  = 1'b1;
                        ram_wrea_d = 1'b1;
                        cg_addr_d  = cg_addr_q + ADDR_W'(1);
                        flip_d     = 1'b0;
                    end
                end else if (bus.data_rd) begin
                    // Address is presented during RD_ADDR so data lands in RD_DATA.
                    ram_ada_d = cg_addr_q;
                    ram_cea_d = 1'b1;
                    state_d   = c_ST_RD_ADDR;
                end
            end
            c_ST_RD_ADDR: begin
                state_d = c_ST_RD_DATA;
            end
            c_ST_RD_DATA: begin
                rd_valid_d = 1'b1;
                state_d    = c_ST_IDLE;
                if (!flip_q) begin
                    cpu_dout_d = bus.ram_douta[7:0];
                    flip_d     = 1'b1;
                end else begin
                    cpu_dout_d = {bus.open_bus7, bus.ram_douta[DATA_W-1:8]};
                    flip_d     = 1'b0;
                    cg_addr_d  = cg_addr_q + ADDR_W'(1);
                end
            end
`ifdef CGRAM_CLEAR_EN
            c_ST_CLEAR: begin
                if (!clr_cnt_q[ADDR_W]) begin
                    ram_ada_d  = clr_cnt_q[ADDR_W-1:0];
                    ram_dina_d = '0;
                    ram_cea_d  = 1'b1;
                    ram_wrea_d = 1'b1;
                    clr_cnt_d  = clr_cnt_q + (ADDR_W+1)'(1);
                end else begin
                    state_d = c_ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= c_ST_RESET;
            cg_addr_q  <= '0;
            flip_q     <= 1'b0;
            lo_latch_q <= '0;
            cpu_dout_q <= '0;
            rd_valid_q <= 1'b0;
            drop_err_q <= 1'b0;
            ram_ada_q  <= '0;
            ram_dina_q <= '0;
            ram_cea_q  <= 1'b0;
            ram_wrea_q <= 1'b0;
`ifdef CGRAM_CLEAR_EN
            clr_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cg_addr_q  <= cg_addr_d;
            flip_q     <= flip_d;
            lo_latch_q <= lo_latch_d;
            cpu_dout_q <= cpu_dout_d;
            rd_valid_q <= rd_valid_d;
            drop_err_q <= drop_err_d;
            ram_ada_q  <= ram_ada_d;
            ram_dina_q <= ram_dina_d;
            ram_cea_q  <= ram_cea_d;
            ram_wrea_q <= ram_wrea_d;
`ifdef CGRAM_CLEAR_EN
            clr_cnt_q  <= clr_cnt_d;
`endif
        end
    end

    assign bus.ready    = (state_q == c_ST_IDLE);
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.drop_err = drop_err_q;
    assign bus.ram_ada  = ram_ada_q;
    assign bus.ram_dina = ram_dina_q;
    assign bus.ram_cea  = ram_cea_q;
    assign bus.ram_wrea = ram_wrea_q;

endmodule
`default_nettype wire

// File: tb/tb_cgram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cgram_port_ctrl
// Brief    : Scoreboard bench for cgram_port_ctrl with a behavioural port-A RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cgram_port_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cgram_port_ctrl_if #(.ADDR_W(8), .DATA_W(15)) bus ();

    cgram_port_ctrl #(.ADDR_W(8), .DATA_W(15)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    logic [14:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_cea) begin
            if (bus.ram_wrea) mem[bus.ram_ada] <= bus.ram_dina;
            else              bus.ram_douta    <= mem[bus.ram_ada];
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  rd_q [$];
    logic [22:0] wr_q [$];
    bit          mon_en = 1'b0;
    logic [7:0]  mon_rd_e;
    logic [22:0] mon_wr_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.rd_valid) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got byte 0x%0h expected no rd_valid", bus.cpu_dout);
                end else begin
                    mon_rd_e = rd_q.pop_front();
                    check("rd_byte", {24'd0, bus.cpu_dout}, {24'd0, mon_rd_e});
                end
            end
            if (mon_en && bus.ram_cea && bus.ram_wrea) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                             bus.ram_ada, bus.ram_dina);
                end else begin
                    mon_wr_e = wr_q.pop_front();
                    check("wr_addr_data", {9'd0, bus.ram_ada, bus.ram_dina}, {9'd0, mon_wr_e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
`ifdef CGRAM_CLEAR_EN
        int n = 0;
        while (!bus.ready && n < 400) begin
            cyc();
            n++;
        end
        check("clear_done_ready", {31'd0, bus.ready}, 32'd1);
`endif
        cyc();
    endtask

    task automatic wr_addr(input logic [7:0] a);
        bus.addr_wr = 1'b1; bus.cpu_din = a;
        cyc();
        bus.addr_wr = 1'b0;
    endtask

    task automatic wr_data(input logic [7:0] d);
        bus.data_wr = 1'b1; bus.cpu_din = d;
        cyc();
        bus.data_wr = 1'b0;
    endtask

    task automatic wr_pair(input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] exp_a, input logic [14:0] exp_d);
        wr_data(lo);
        wr_q.push_back({exp_a, exp_d});
        wr_data(hi);
    endtask

    task automatic do_rd(input logic [7:0] exp);
        int n;
        rd_q.push_back(exp);
        bus.data_rd = 1'b1;
        cyc();
        bus.data_rd = 1'b0;
        n = 1;
        while (!bus.rd_valid && n < 10) begin
            cyc();
            n++;
        end
        check("rd_latency", n, 32'd3);
    endtask

    initial begin
        bus.addr_wr = 1'b0; bus.data_wr = 1'b0; bus.data_rd = 1'b0;
        bus.cpu_din = 8'h00; bus.open_bus7 = 1'b0;
        resetn = 1'b0;
        cyc(); cyc();
        check("rst_cpu_dout", {24'd0, bus.cpu_dout}, 32'd0);
        check("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        check("rst_drop_err", {31'd0, bus.drop_err}, 32'd0);
        check("rst_ram_ada",  {24'd0, bus.ram_ada},  32'd0);
        check("rst_ram_dina", {17'd0, bus.ram_dina}, 32'd0);
        check("rst_ram_cea",  {31'd0, bus.ram_cea},  32'd0);
        check("rst_ram_wrea", {31'd0, bus.ram_wrea}, 32'd0);
`ifdef CGRAM_CLEAR_EN
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
`else
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
`endif
        resetn = 1'b1;
        wait_ready();
        mon_en = 1'b1;

        // Basic write pair and auto-increment
        wr_addr(8'h10);
        wr_pair(8'h1F, 8'h7C, 8'h10, 15'h7C1F);
        wr_pair(8'h01, 8'h02, 8'h11, 15'h0201);

        // Address wrap 0xFF -> 0x00
        wr_addr(8'hFF);
        wr_pair(8'h34, 8'h12, 8'hFF, 15'h1234);
        wr_pair(8'hAA, 8'h55, 8'h00, 15'h55AA);

        // Two-phase read with open-bus bit
        wr_addr(8'h05);
        wr_pair(8'hBC, 8'h6A, 8'h05, 15'h6ABC);
        bus.open_bus7 = 1'b1;
        wr_addr(8'h05);
        do_rd(8'hBC);
        do_rd(8'hEA);
        wr_pair(8'h0F, 8'h01, 8'h06, 15'h010F);

        // Shared flip: low-byte write then read returns high byte
        bus.open_bus7 = 1'b0;
        wr_addr(8'h10);
        wr_data(8'h99);
        do_rd(8'h7C);
        wr_pair(8'h03, 8'h04, 8'h11, 15'h0403);
        bus.open_bus7 = 1'b1;
        wr_addr(8'h11);
        do_rd(8'h03);
        do_rd(8'h84);

        // Priority: addr_wr beats data_wr and clears the flip
        wr_data(8'h55);
        bus.addr_wr = 1'b1; bus.data_wr = 1'b1; bus.cpu_din = 8'h20;
        cyc();
        bus.addr_wr = 1'b0; bus.data_wr = 1'b0;
        check("prio_no_drop", {31'd0, bus.drop_err}, 32'd0);
        wr_pair(8'h11, 8'h22, 8'h20, 15'h2211);

        // Priority: data_wr beats data_rd
        wr_addr(8'h30);
        bus.data_wr = 1'b1; bus.data_rd = 1'b1; bus.cpu_din = 8'h44;
        cyc();
        bus.data_wr = 1'b0; bus.data_rd = 1'b0;
        wr_q.push_back({8'h30, 15'h3344});
        wr_data(8'h33);
        check("prio2_no_drop", {31'd0, bus.drop_err}, 32'd0);

        // Strobe while busy is dropped and flagged
        wr_addr(8'h05);
        rd_q.push_back(8'hBC);
        bus.data_rd = 1'b1;
        cyc();
        cyc();
        bus.data_rd = 1'b0;
        check("busy_ready_low", {31'd0, bus.ready}, 32'd0);
        check("busy_drop_err", {31'd0, bus.drop_err}, 32'd1);
        begin
            int n = 0;
            while (!bus.rd_valid && n < 10) begin
                cyc();
                n++;
            end
            check("busy_rd_done", {31'd0, bus.rd_valid}, 32'd1);
        end
        cyc(); cyc();
        check("drop_sticky", {31'd0, bus.drop_err}, 32'd1);

        // Reset during a read abandons it
        bus.data_rd = 1'b1;
        cyc();
        bus.data_rd = 1'b0;
        mon_en = 1'b0;
        resetn = 1'b0;
        cyc();
        check("abort_cea", {31'd0, bus.ram_cea}, 32'd0);
        check("abort_drop_clr", {31'd0, bus.drop_err}, 32'd0);
        resetn = 1'b1;
        repeat (4) cyc();
        wait_ready();
        mon_en = 1'b1;
        check("abort_cpu_dout", {24'd0, bus.cpu_dout}, 32'd0);
        wr_pair(8'h66, 8'h77, 8'h00, 15'h7766);

`ifdef CGRAM_CLEAR_EN
        // Full clear sequence timing
        mon_en = 1'b0;
        resetn = 1'b0;
        cyc(); cyc();
        resetn = 1'b1;
        check("clr_c0_ready", {31'd0, bus.ready}, 32'd0);
        for (int k = 0; k < 256; k++) begin
            cyc();
            check("clr_ctrl", {31'd0, (bus.ram_cea && bus.ram_wrea && bus.ram_dina == 15'd0 && !bus.ready)}, 32'd1);
            check("clr_addr", {24'd0, bus.ram_ada}, k);
        end
        cyc();
        check("clr_ready", {31'd0, bus.ready}, 32'd1);
        check("clr_idle_cea", {31'd0, bus.ram_cea}, 32'd0);

        // Strobe during clear, then reset at clear cycle 100
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (k == 50) bus.addr_wr = 1'b1;
            cyc();
            bus.addr_wr = 1'b0;
        end
        check("clr_drop_err", {31'd0, bus.drop_err}, 32'd1);
        resetn = 1'b0;
        cyc();
        check("clr_abort_cea", {31'd0, bus.ram_cea}, 32'd0);
        resetn = 1'b1;
        cyc();
        check("clr_restart_addr", {24'd0, bus.ram_ada}, 32'd0);
        check("clr_restart_cea", {31'd0, bus.ram_cea}, 32'd1);
        wait_ready();
        mon_en = 1'b1;
`endif

        repeat (3) cyc();
        check("rd_q_empty", rd_q.size(), 32'd0);
        check("wr_q_empty", wr_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cgram_port_ctrl.md
Name: cgram_port_ctrl

Overview:
- CPU-side sequencer for the 256 x 15-bit palette RAM (CGRAM), driving port A of the dual-port palette block. Port B stays with the renderer and is not touched here.
- Converts the PPU byte-wide register accesses into 15-bit RAM accesses:
  - address set ($2121)
  - data write with low-byte latch ($2122)
  - two-phase read ($213B)
- Handles the byte flip-flop, address auto-increment and the 1-cycle synchronous-read latency, plus an optional post-reset palette clear.

Parameters:
- ADDR_W, 8, CGRAM word address width (256 entries).
- DATA_W, 15, CGRAM word width (BGR555).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- addr_wr  in  1  1-cycle strobe: CPU write to address register.
- data_wr  in  1  1-cycle strobe: CPU write to data register.
- data_rd  in  1  1-cycle strobe: CPU read of data register.
- cpu_din  in  8  CPU write byte, valid with addr_wr/data_wr.
- open_bus7  in  1  PPU2 open-bus bit, returned as bit 7 of a high-byte read.
- cpu_dout  out  8  read byte; holds value until next read completes.
- rd_valid  out  1  1-cycle pulse when cpu_dout updated.
- ready  out  1  high when strobes are accepted.
- drop_err  out  1  sticky: a strobe arrived while ready=0.
- ram_ada  out  8  port A address (registered).
- ram_dina  out  15  port A write data (registered).
- ram_cea  out  1  port A clock enable (registered).
- ram_wrea  out  1  port A write enable (registered).
- ram_douta  in  15  port A read data; valid the cycle after the RAM edge sampling ram_cea=1.

Behaviour:
- Reset/clock: Already decided — one clock (clk); reset is synchronous and active-low (resetn).
- Reset values:
  - cpu_dout=0, rd_valid=0, drop_err=0.
  - ram_ada=0, ram_dina=0, ram_cea=0, ram_wrea=0.
  - Internal state: cg_addr=0, flip=0, lo_latch=0.
  - ready=0 if CGRAM_CLEAR_EN, else 1.
- Reset mid-operation: any pending read or clear is abandoned with no completion pulse, and all state is reset as above.
- States:
  - CLEAR (only with macro) -> IDLE.
  - IDLE -> RD_ADDR on data_rd.
  - RD_ADDR -> RD_DATA.
  - RD_DATA -> IDLE.
- ready: 1 only in IDLE.
- Strobe priority: if more than one strobe is high in a cycle, only the highest is acted on: addr_wr > data_wr > data_rd. The lower strobes are ignored and do not set drop_err.
- Strobes arriving when ready=0: ignored and set drop_err=1; it clears only on reset.
- addr_wr (IDLE): cg_addr<=cpu_din; flip<=0.
- data_wr, flip=0: lo_latch<=cpu_din; flip<=1; no RAM access.
- data_wr, flip=1:
  - Next cycle: ram_ada=cg_addr, ram_dina={cpu_din[6:0],lo_latch}, ram_cea=1, ram_wrea=1 for exactly 1 cycle. cpu_din[7] is discarded.
  - cg_addr<=cg_addr+1, mod 256 (255 wraps to 0); flip<=0.
  - Stays in IDLE, so back-to-back strobes are allowed.
- data_rd, cycle 0 (IDLE): strobe accepted.
- Cycle 1 (RD_ADDR): ram_ada=cg_addr, ram_cea=1, ram_wrea=0.
- Cycle 2 (RD_DATA): ram_douta is valid and is sampled.
- Cycle 3: cpu_dout updated and rd_valid=1. Read latency is 3 cycles from strobe.
  - flip=0: cpu_dout=douta[7:0]; flip<=1.
  - flip=1: cpu_dout={open_bus7,douta[14:8]}; flip<=0; cg_addr+1 with wrap.
- Read and write share the flip: a low-byte write followed by a read returns the high byte of the current entry. This is intentional, matching hardware.
- ram_cea/ram_wrea are deasserted in every cycle with no access.

Optional Feature:
- Macro: CGRAM_CLEAR_EN.
- Defined:
  - After resetn rises, FSM enters CLEAR and writes 0 to addresses 0..255, one per cycle (ram_cea=ram_wrea=1, ram_dina=0), for 256 cycles.
  - ready rises in the cycle after address 255 is written, with cg_addr=0 and flip=0.
  - Strobes during CLEAR set drop_err.
- Undefined: no CLEAR state; ready=1 from the first cycle after reset and RAM contents are untouched.

Test Plan:
- addr_wr 0x10; data_wr 0x1F; data_wr 0x7C -> single port-A write at addr 0x10 with dina=0x7C1F; next access targets 0x11.
- addr_wr 0xFF; two data_wr 0x34, 0x12 -> write 0x1234 at 0xFF; cg_addr wraps to 0x00; following pair writes addr 0x00.
- Entry 0x05=0x6ABC, open_bus7=1; addr_wr 0x05; data_rd; data_rd -> bytes 0xBC then 0xEA; rd_valid 3 cycles after each strobe; cg_addr=0x06.
- addr_wr and data_wr high in the same cycle -> only address loaded, flip=0, no drop_err; data_rd during RD_ADDR -> ignored, drop_err=1.
- CGRAM_CLEAR_EN defined: release reset -> 256 consecutive zero writes to 0..255, ready=0 throughout and 1 on the next cycle; assert resetn low at clear cycle 100 -> clear restarts from 0 after release.
- Low-byte data_wr then data_rd -> high byte of the current entry returned; flip=0 and addr+1 afterwards.
